// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// div_arbiter: round-robin sequencer sharing one divider among NREQ requesters
// Revision: 1.0
// ============================================================================
module div_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 80,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_q,
    output logic [W-1:0]      rsp_r,
    output logic [1:0]        rsp_err,
    input  logic              rsp_ack,
    output logic              div_start,
    output logic [W-1:0]      div_a,
    output logic [W-1:0]      div_b,
    input  logic              div_ready,
    input  logic              div_done,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r,
    output logic              busy
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0]     c_ERR_OK   = 2'b00;
    localparam logic [1:0]     c_ERR_DIV0 = 2'b01;
    localparam logic [1:0]     c_ERR_TMO  = 2'b10;
    localparam logic [IDW:0]   c_NREQ     = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] c_LAST_RST = IDW'(NREQ - 1);
    localparam logic [WD_W-1:0] c_WD_LOAD = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] c_WD_ONE  = WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_idx;
    logic [WD_W-1:0] r_wd;

    logic [IDW-1:0]  w_win;
    logic            w_win_vld;
    logic            w_grant;
    logic            w_wd_expire;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [W-1:0]    w_a_arr [NREQ];
    logic [W-1:0]    w_b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = req_a[gi*W +: W];
        assign w_b_arr[gi] = req_b[gi*W +: W];
    end

    // Scan from the farthest candidate down so the nearest valid index after
    // r_last is the one left standing.
    always_comb begin : arb
        logic [IDW:0] v_sum;
        w_win     = '0;
        w_win_vld = 1'b0;
        v_sum     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            v_sum = {1'b0, r_last} + (IDW+1)'(k);
            if (v_sum >= c_NREQ) begin
                v_sum = v_sum - c_NREQ;
            end
            if (req_valid[v_sum[IDW-1:0]]) begin
                w_win     = v_sum[IDW-1:0];
                w_win_vld = 1'b1;
            end
        end
    end

    assign w_sel_a     = w_a_arr[w_win];
    assign w_sel_b     = w_b_arr[w_win];
    // Gated by rst so req_ready is also quiet while reset is held.
    assign w_grant     = rst && (r_state == S_IDLE) && w_win_vld && div_ready;
    assign w_wd_expire = (r_wd <= c_WD_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        div_start   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    req_ready[w_win] = 1'b1;
                    w_state_nxt      = (w_sel_b == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start   = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (div_done || w_wd_expire) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= c_LAST_RST;
            r_idx   <= '0;
            r_wd    <= '0;
            div_a   <= '0;
            div_b   <= '0;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_err <= c_ERR_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_idx <= w_win;
                        div_a <= w_sel_a;
                        div_b <= w_sel_b;
                        if (w_sel_b == '0) begin
                            rsp_q   <= '0;
                            rsp_r   <= '0;
                            rsp_err <= c_ERR_DIV0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wd <= c_WD_LOAD;
                end
                S_WAIT: begin
                    // A done pulse in the expiry cycle still counts as success.
                    if (div_done) begin
                        rsp_q   <= div_q;
                        rsp_r   <= div_r;
                        rsp_err <= c_ERR_OK;
                    end else if (w_wd_expire) begin
                        rsp_q   <= '0;
                        rsp_r   <= '0;
                        rsp_err <= c_ERR_TMO;
                        r_wd    <= '0;
                    end else begin
                        r_wd <= r_wd - c_WD_ONE;
                    end
                end
                S_RESP: begin
                    if (rsp_ack) begin
                        r_last <= r_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_idx;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Round-robin arbiter and sequencer that shares one restoring divider among NREQ requesters. It accepts one operand pair at a time, screens out divide-by-zero, and issues a single-cycle start to the divider. It then waits for completion under a watchdog and returns quotient/remainder, tagged with the requester index, over a valid/ack response channel. It sits between the bus-side requester ports and the divider instance.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/result width; must match the divider
TIMEOUT, 80, cycles allowed in WAIT before declaring timeout
IDW, $clog2(NREQ), requester index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
req_valid  in  NREQ  per-requester request pending
req_a  in  NREQ*W  dividends, requester i at [i*W +: W]
req_b  in  NREQ*W  divisors, same packing
req_ready  out  NREQ  one-hot single-cycle accept pulse
rsp_valid  out  1  response available
rsp_id  out  IDW  index of the requester owning the response
rsp_q  out  W  quotient
rsp_r  out  W  remainder
rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout
rsp_ack  in  1  response consumed
div_start  out  1  start pulse to divider
div_a  out  W  dividend to divider
div_b  out  W  divisor to divider
div_ready  in  1  divider idle/ready
div_done  in  1  divider completion pulse (one cycle)
div_q  in  W  divider quotient
div_r  in  W  divider remainder
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, last_grant=NREQ-1, and all outputs 0 (req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_start, div_a, div_b, busy). Watchdog cleared. Reset mid-operation abandons the transaction; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: when |req_valid and div_ready=1, grant the first valid index searching last_grant+1, +2, ... modulo NREQ.
  - In that same cycle, req_ready[winner]=1 (combinational, one-hot).
  - On the clock edge, latch idx, div_a<=req_a[idx], div_b<=req_b[idx].
  - If req_b[idx]==0, go to RESP with rsp_err=01, rsp_q=0, rsp_r=0; the divider is never started.
  - Otherwise go to ISSUE. If div_ready=0, no grant is made.
- ISSUE: div_start=1 for exactly this one cycle; watchdog loaded with TIMEOUT; go to WAIT.
- WAIT: div_start=0; div_a/div_b held stable until leaving WAIT.
  - On div_done=1: capture rsp_q<=div_q, rsp_r<=div_r, rsp_err<=00; go to RESP.
  - Otherwise decrement the watchdog. When it reaches 0 without done: rsp_err<=10, rsp_q/r<=0; go to RESP.
  - div_done and watchdog expiry in the same cycle: done wins.
- RESP: rsp_valid=1, rsp_id=idx. Data is held stable until rsp_ack=1. On ack: rsp_valid falls next cycle, last_grant<=idx, go to IDLE.
- rsp_ack outside RESP is ignored. div_done outside WAIT is ignored.
- req_valid may drop without being granted; there is no request queuing.
- Fairness: a continuously requesting port waits at most NREQ-1 transactions.
- Throughput: a new grant is possible in the cycle after the ack (first IDLE cycle).
- Operands are two's complement and passed unmodified; sign handling is the divider's job.

Test Plan:
- Single request: req 1, a=100, b=7 -> req_ready[1] one pulse, div_start one pulse, after div_done rsp_valid with id=1, q=14, r=2, err=00.
- Signed: a=-100 (0xFF9C), b=7 -> q=0xFFF2 (-14), r=0xFFFE (-2), err=00.
- Divide-by-zero: req 2, b=0 -> div_start never asserted; RESP with id=2, err=01, q=r=0 within 2 cycles of grant.
- Round-robin: all 4 requesters hold req_valid from reset -> grant order 0,1,2,3,0; each grant only after the previous rsp_ack.
- Timeout: divider model never pulses div_done -> rsp_err=10 exactly TIMEOUT+1 cycles after ISSUE; a simultaneous done/expiry case returns err=00.
- Reset mid-WAIT: drop rst during WAIT -> all outputs 0 immediately; after release, requester 0 has priority and no stale response appears.
